// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between a FIFO user and sync_fifo_ctrl.
// The master side pushes and pops; the slave side is the FIFO itself.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, w_en, data_in, r_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, w_en, data_in, r_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with any DEPTH >= 2, occupancy count, almost flags,
// synchronous flush, overflow/underflow pulses, and FWFT or registered read.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter bit FWFT       = 1'b0,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_ctrl_if.slave fifo
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THR   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THR   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         cnt;
    logic                  is_empty;
    logic                  is_full;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  wr_go;
    logic                  ovf_q;
    logic                  unf_q;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);

    // A full FIFO still takes a write when the same edge pops a word.
    assign rd_acc = fifo.r_en & ~is_empty;
    assign wr_acc = fifo.w_en & (~is_full | rd_acc);
    assign wr_go  = wr_acc & ~fifo.flush;

    // Explicit wrap so non-power-of-two depths use every entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
        end else if (fifo.flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
        end else begin
            if (wr_acc) w_ptr <= ptr_inc(w_ptr);
            if (rd_acc) r_ptr <= ptr_inc(r_ptr);
            if (wr_acc & ~rd_acc)
                cnt <= cnt + CW'(1);
            else if (rd_acc & ~wr_acc)
                cnt <= cnt - CW'(1);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_go) mem[w_ptr] <= fifo.data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ~fifo.flush & fifo.w_en & ~wr_acc;
            unf_q <= ~fifo.flush & fifo.r_en & ~rd_acc;
        end
    end

    assign fifo.count        = cnt;
    assign fifo.full         = is_full;
    assign fifo.empty        = is_empty;
    assign fifo.almost_full  = (cnt >= AF_THR);
    assign fifo.almost_empty = (cnt <= AE_THR);
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;

    generate
        if (FWFT) begin : g_fwft
            // Head word is always on the bus; r_en acknowledges it.
            assign fifo.data_out = mem[r_ptr];
            assign fifo.rd_valid = ~is_empty;
        end else begin : g_reg
            logic                  rd_go;
            logic                  rd_vld_q;
            logic [DATA_WIDTH-1:0] dout_q;

            assign rd_go = rd_acc & ~fifo.flush;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_vld_q <= 1'b0;
                    dout_q   <= '0;
                end else begin
                    rd_vld_q <= rd_go;
                    if (rd_go) dout_q <= mem[r_ptr];
                end
            end

            assign fifo.data_out = dout_q;
            assign fifo.rd_valid = rd_vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: three configurations share one stimulus stream,
// a queue-based model predicts every output, and directed literals pin it.
module tb_sync_fifo_ctrl;
    localparam int     N = 3;
    localparam int     P_DEPTH [N] = '{8, 6, 8};
    localparam bit     P_FWFT  [N] = '{1'b0, 1'b0, 1'b1};
    localparam int     P_AF    [N] = '{7, 5, 6};
    localparam int     P_AE    [N] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    bit         chk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(8)) ifa ();
    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(6)) ifb ();
    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(8)) ifc ();

    assign ifa.flush = flush;  assign ifa.w_en = w_en;
    assign ifa.r_en = r_en;    assign ifa.data_in = data_in;
    assign ifb.flush = flush;  assign ifb.w_en = w_en;
    assign ifb.r_en = r_en;    assign ifb.data_in = data_in;
    assign ifc.flush = flush;  assign ifc.w_en = w_en;
    assign ifc.r_en = r_en;    assign ifc.data_in = data_in;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b0)) u_a (
        .clk(clk), .rst(rst), .fifo(ifa));
    sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(1'b0)) u_b (
        .clk(clk), .rst(rst), .fifo(ifb));
    sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b1),
                     .AF_LEVEL(6), .AE_LEVEL(2)) u_c (
        .clk(clk), .rst(rst), .fifo(ifc));

    logic [7:0] o_dout [N];
    logic [3:0] o_cnt  [N];
    logic       o_rdv  [N];
    logic       o_full [N];
    logic       o_emp  [N];
    logic       o_af   [N];
    logic       o_ae   [N];
    logic       o_ovf  [N];
    logic       o_unf  [N];

    assign o_dout[0] = ifa.data_out; assign o_dout[1] = ifb.data_out; assign o_dout[2] = ifc.data_out;
    assign o_cnt[0]  = ifa.count;    assign o_cnt[1]  = {1'b0, ifb.count}; assign o_cnt[2] = ifc.count;
    assign o_rdv[0]  = ifa.rd_valid; assign o_rdv[1]  = ifb.rd_valid; assign o_rdv[2]  = ifc.rd_valid;
    assign o_full[0] = ifa.full;     assign o_full[1] = ifb.full;     assign o_full[2] = ifc.full;
    assign o_emp[0]  = ifa.empty;    assign o_emp[1]  = ifb.empty;    assign o_emp[2]  = ifc.empty;
    assign o_af[0]   = ifa.almost_full;  assign o_af[1] = ifb.almost_full;  assign o_af[2] = ifc.almost_full;
    assign o_ae[0]   = ifa.almost_empty; assign o_ae[1] = ifb.almost_empty; assign o_ae[2] = ifc.almost_empty;
    assign o_ovf[0]  = ifa.overflow; assign o_ovf[1] = ifb.overflow;  assign o_ovf[2] = ifc.overflow;
    assign o_unf[0]  = ifa.underflow; assign o_unf[1] = ifb.underflow; assign o_unf[2] = ifc.underflow;

    // Model: contents as a plain queue, plus the registered-read side effects.
    logic [7:0] mq [N][$];
    logic [7:0] e_dout [N];
    bit         e_rdv [N];
    bit         e_ovf [N];
    bit         e_unf [N];
    int         m_n;
    bit         m_rd, m_wr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                e_dout[i] = 8'h00; e_rdv[i] = 0; e_ovf[i] = 0; e_unf[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_n = mq[i].size();
                if (flush) begin
                    mq[i].delete();
                    e_rdv[i] = 0; e_ovf[i] = 0; e_unf[i] = 0;
                end else begin
                    m_rd = r_en && (m_n > 0);
                    m_wr = w_en && ((m_n < P_DEPTH[i]) || m_rd);
                    e_rdv[i] = m_rd;
                    if (m_rd) e_dout[i] = mq[i].pop_front();
                    if (m_wr) mq[i].push_back(data_in);
                    e_ovf[i] = w_en && !m_wr;
                    e_unf[i] = r_en && !m_rd;
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                int sz;
                sz = mq[i].size();
                chk("count", i, int'(o_cnt[i]), sz);
                chk("empty", i, int'(o_emp[i]), int'(sz == 0));
                chk("full", i, int'(o_full[i]), int'(sz == P_DEPTH[i]));
                chk("almost_full", i, int'(o_af[i]), int'(sz >= P_AF[i]));
                chk("almost_empty", i, int'(o_ae[i]), int'(sz <= P_AE[i]));
                chk("overflow", i, int'(o_ovf[i]), int'(e_ovf[i]));
                chk("underflow", i, int'(o_unf[i]), int'(e_unf[i]));
                if (P_FWFT[i]) begin
                    chk("rd_valid", i, int'(o_rdv[i]), int'(sz != 0));
                    if (sz != 0) chk("data_out", i, int'(o_dout[i]), int'(mq[i][0]));
                end else begin
                    chk("rd_valid", i, int'(o_rdv[i]), int'(e_rdv[i]));
                    chk("data_out", i, int'(o_dout[i]), int'(e_dout[i]));
                end
            end
        end
    end

    // One clock of stimulus; returns 2 time units after the edge.
    task automatic cyc(input bit we, input bit re, input logic [7:0] d, input bit fl);
        w_en = we; r_en = re; data_in = d; flush = fl;
        @(posedge clk); #2;
        w_en = 0; r_en = 0; flush = 0;
    endtask

    logic [7:0] got [$];

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk_en = 1;
        chk("rst_empty", 0, int'(ifa.empty), 1);
        chk("rst_almost_empty", 0, int'(ifa.almost_empty), 1);
        chk("rst_full", 0, int'(ifa.full), 0);
        chk("rst_count", 0, int'(ifa.count), 0);
        chk("rst_data_out", 0, int'(ifa.data_out), 0);
        chk("rst_rd_valid", 0, int'(ifa.rd_valid), 0);

        // Asynchronous reset with three words stored
        cyc(1, 0, 8'h11, 0); cyc(1, 0, 8'h22, 0); cyc(1, 0, 8'h33, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(1, 0, 8'h44, 0);
        chk("pre_rst_count", 0, int'(ifa.count), 3);
        chk("pre_rst_dout", 0, int'(ifa.data_out), 8'h11);
        #4 rst = 1;
        #1;
        chk("async_count", 0, int'(ifa.count), 0);
        chk("async_empty", 0, int'(ifa.empty), 1);
        chk("async_dout", 0, int'(ifa.data_out), 0);
        chk("async_almost_empty", 0, int'(ifa.almost_empty), 1);
        #1 rst = 0;
        @(posedge clk); #2;

        // Fill to full, then overflow, then drain in order
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 8'(k), 0);
            chk("fill_count", 0, int'(ifa.count), k);
            chk("fill_almost_full", 0, int'(ifa.almost_full), int'(k >= 7));
        end
        chk("fill_full", 0, int'(ifa.full), 1);
        cyc(1, 0, 8'h09, 0);
        chk("ovf_pulse", 0, int'(ifa.overflow), 1);
        chk("ovf_count", 0, int'(ifa.count), 8);
        cyc(0, 0, 8'h00, 0);
        chk("ovf_clear", 0, int'(ifa.overflow), 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1, 8'h00, 0);
            chk("drain_rd_valid", 0, int'(ifa.rd_valid), 1);
            chk("drain_data", 0, int'(ifa.data_out), k);
        end
        cyc(0, 0, 8'h00, 0);
        chk("drain_empty", 0, int'(ifa.empty), 1);
        chk("drain_rd_valid_low", 0, int'(ifa.rd_valid), 0);

        // Simultaneous write/read on full, then on empty
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'(8'h40 + k), 0);
        cyc(1, 1, 8'h50, 0);
        chk("full_wr_rd_count", 0, int'(ifa.count), 8);
        chk("full_wr_rd_ovf", 0, int'(ifa.overflow), 0);
        chk("full_wr_rd_dout", 0, int'(ifa.data_out), 8'h40);
        for (int k = 0; k < 8; k++) cyc(0, 1, 8'h00, 0);
        chk("full_wr_rd_last", 0, int'(ifa.data_out), 8'h50);
        cyc(1, 1, 8'h66, 0);
        chk("empty_wr_rd_count", 0, int'(ifa.count), 1);
        chk("empty_wr_rd_unf", 0, int'(ifa.underflow), 1);
        cyc(0, 1, 8'h00, 0);
        chk("empty_wr_rd_data", 0, int'(ifa.data_out), 8'h66);

        // DEPTH=6 wrap-around: 20 words, both pointers wrap three times
        got.delete();
        for (int k = 0; k < 26; k++) begin
            cyc(k < 20, k >= 6, 8'(8'h80 + k), 0);
            if (int'(ifb.count) > 6) chk("wrap_count_bound", 1, int'(ifb.count), 6);
            if (ifb.rd_valid) got.push_back(ifb.data_out);
        end
        chk("wrap_len", 1, got.size(), 20);
        for (int k = 0; k < 20 && k < got.size(); k++)
            chk("wrap_order", 1, int'(got[k]), 8'h80 + k);

        // FWFT visibility
        cyc(1, 0, 8'hA5, 0);
        chk("fwft_data", 2, int'(ifc.data_out), 8'hA5);
        chk("fwft_rd_valid", 2, int'(ifc.rd_valid), 1);
        chk("fwft_empty", 2, int'(ifc.empty), 0);
        chk("fwft_reg_side", 0, int'(ifa.rd_valid), 0);
        cyc(0, 1, 8'h00, 0);
        chk("fwft_pop_empty", 2, int'(ifc.empty), 1);
        chk("reg_pop_data", 0, int'(ifa.data_out), 8'hA5);

        // Flush beats simultaneous write and read
        for (int k = 1; k <= 5; k++) cyc(1, 0, 8'(8'h30 + k), 0);
        chk("pre_flush_count", 2, int'(ifc.count), 5);
        chk("pre_flush_af", 2, int'(ifc.almost_full), 0);
        chk("pre_flush_ae", 2, int'(ifc.almost_empty), 0);
        cyc(1, 1, 8'h99, 1);
        chk("flush_count", 2, int'(ifc.count), 0);
        chk("flush_empty", 2, int'(ifc.empty), 1);
        chk("flush_ovf", 2, int'(ifc.overflow), 0);
        chk("flush_unf", 2, int'(ifc.underflow), 0);
        chk("flush_hold_dout", 0, int'(ifa.data_out), 8'hA5);
        chk("flush_rd_valid", 0, int'(ifa.rd_valid), 0);
        cyc(1, 0, 8'h3C, 0);
        chk("post_flush_fwft", 2, int'(ifc.data_out), 8'h3C);
        cyc(0, 1, 8'h00, 0);
        chk("post_flush_reg", 0, int'(ifa.data_out), 8'h3C);
        chk("post_flush_empty", 2, int'(ifc.empty), 1);
        cyc(0, 0, 8'h00, 0);

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO and the next generation of the crypto datapath's buffer.
- Sits between the AXI-stream side and the cipher core, and between the core and the output DMA.
- Over the previous FIFO it adds: all DEPTH entries usable, non-power-of-two depths, first-word-fall-through (FWFT) or registered-read mode, occupancy count, almost-full/almost-empty thresholds, synchronous flush, and overflow/underflow pulses.

Parameters:
- DATA_WIDTH, 8: width of each data word.
- DEPTH, 8: number of storage entries; any integer >= 2, power of two not required.
- FWFT, 0: 0 = registered-read mode; 1 = first-word-fall-through mode.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of contents.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (pop).
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds a newly popped word (registered mode); equals !empty in FWFT mode.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset is asynchronous and active-high. With rst=1:
  - pointers = 0, count = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1 (AE_LEVEL >= 0), almost_full = 0.
  - Memory contents are not reset.
- Accept rules, evaluated on the same clock edge:
  - rd_acc = r_en & !empty.
  - wr_acc = w_en & (!full | rd_acc). A write to a full FIFO succeeds when a read is accepted in the same cycle.
  - Read and write on an empty FIFO: the write is accepted, the read is rejected and underflow pulses.
- Pointers: w_ptr and r_ptr are each $clog2(DEPTH) wide. Each advances by 1 on accept and wraps from DEPTH-1 to 0 by explicit compare, not modulo 2^n.
- Count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never exceeds DEPTH; never underflows below 0.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They take effect the cycle after the accepting edge and have no further latency.
- Registered mode (FWFT=0):
  - On rd_acc, data_out <= mem[r_ptr] and rd_valid <= 1 the following cycle (read latency 1).
  - Otherwise rd_valid <= 0 and data_out holds its value.
- FWFT mode (FWFT=1):
  - data_out = mem[r_ptr] combinationally and rd_valid = !empty.
  - The first word written into an empty FIFO is visible the cycle after the write edge.
  - r_en acknowledges (pops) the displayed word.
- Write/read collision: with count == 0, a same-cycle write is not readable in that cycle; there is no bypass path.
- overflow <= w_en & !wr_acc; underflow <= r_en & !rd_acc. Both are single-cycle registered pulses and never sticky.
- flush:
  - Has priority over w_en and r_en in the same cycle.
  - Next cycle: pointers = 0, count = 0, rd_valid = 0, no overflow/underflow pulse. data_out keeps its value in registered mode.
- rst asserted mid-operation: immediate return to the reset state. Words in flight are discarded.
- Data ordering is strictly FIFO, with no reordering or duplication across wrap-around.

Test Plan:
- Reset, then idle:
  - Required: empty=1, almost_empty=1, full=0, count=0, data_out=0, rd_valid=0.
  - Assert rst asynchronously mid-cycle with count=3: outputs return to those values before the next edge.
- DEPTH=8, FWFT=0: write 0x01..0x08 on consecutive cycles.
  - Required: full=1 and count=8 after the 8th edge; almost_full from count=7.
  - A 9th write gives overflow=1 for one cycle, count stays 8.
  - Then 8 reads return 0x01..0x08, each with rd_valid one cycle after r_en.
- DEPTH=6 (non-power-of-two), FWFT=0: 20 interleaved writes/reads so both pointers wrap at least 3 times.
  - Required: output sequence identical to the input, count never > 6.
- Full FIFO (DEPTH=8) with w_en=1 and r_en=1 in the same cycle.
  - Required: both accepted, count stays 8, no overflow.
  - Empty FIFO with both asserted: write accepted, count=1, underflow pulses.
- FWFT=1: write 0xA5 into the empty FIFO.
  - Required: the cycle after the write edge, data_out=0xA5, rd_valid=1, empty=0.
  - A read pop then gives empty=1 the following cycle.
- count=5 (DEPTH=8, AE_LEVEL=2, AF_LEVEL=6); assert flush with w_en=1 and r_en=1.
  - Required: next cycle count=0, empty=1, no overflow/underflow pulse.
  - A subsequent write 0x3C reads back as 0x3C.
